// File: rtl/vend_pkg.sv
// Shared coin codes and feeder state encoding for the newspaper vending
// datapath; imported by the coin feeder and the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_0  = 2'b00,
    COIN_5  = 2'b01,
    COIN_10 = 2'b10
  } coin_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } feeder_state_t;

  // Monetary value of a coin code in cents; 11 is never produced.
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 8'd5;
      COIN_10: coin_value = 8'd10;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Saturating run-length counter for one coin-slot sensor; o_qualify fires
// once per high run, on the edge where the count reaches DEBOUNCE.
module coin_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sense,
  output logic o_qualify
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_sense) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Combinational so the FIFO write lands on the qualifying edge itself.
  assign o_qualify = i_sense && (r_cnt == CNT_LAST);

endmodule

// File: rtl/coin_feeder.sv
// Coin-acceptor front end: debounced sensors feed a coin FIFO drained by a
// paced IDLE/ISSUE/GAP issuer. COIN_FEEDER_TALLY_EN adds an 8-bit tally output.
module coin_feeder
  import vend_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sense5,
  input  logic          sense10,
  input  logic          newspaper,
  output logic [1:0]    coin,
  output logic          full,
  output logic          reject,
  output feeder_state_t o_dbg_state
`ifdef COIN_FEEDER_TALLY_EN
  ,
  output logic [7:0]    tally
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic          w_ev5;
  logic          w_ev10;
  logic          w_single;
  logic          w_both;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [1:0]    w_code;
  logic [AW:0]   w_count_next;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_reject;
  logic [1:0]    r_coin;
  feeder_state_t r_state;

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb5 (
    .clock     (clock),
    .reset     (reset),
    .i_sense   (sense5),
    .o_qualify (w_ev5)
  );

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb10 (
    .clock     (clock),
    .reset     (reset),
    .i_sense   (sense10),
    .o_qualify (w_ev10)
  );

  assign w_single = w_ev5 ^ w_ev10;
  assign w_both   = w_ev5 & w_ev10;
  // Uses the registered full flag, so a same-edge pop never rescues a coin.
  assign w_push   = w_single & ~r_full;
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && !newspaper && (r_state != ISSUE);
  assign w_code   = w_ev10 ? COIN_10 : COIN_5;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == COUNT_FULL);
      r_reject <= w_both | (w_single & r_full);
    end
  end

  // The forced GAP after every ISSUE gives the controller one cycle to raise
  // newspaper before another coin can be presented.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_coin  <= COIN_0;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          if (w_pop) begin
            r_state <= ISSUE;
            r_coin  <= r_mem[r_rd_ptr];
          end else begin
            r_state <= IDLE;
            r_coin  <= COIN_0;
          end
        end
        ISSUE: begin
          r_state <= GAP;
          r_coin  <= COIN_0;
        end
        default: begin
          r_state <= IDLE;
          r_coin  <= COIN_0;
        end
      endcase
    end
  end

`ifdef COIN_FEEDER_TALLY_EN
  logic [7:0] r_tally;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tally <= '0;
    end else if (w_pop) begin
      r_tally <= r_tally + coin_value(r_mem[r_rd_ptr]);
    end
  end

  assign tally = r_tally;
`endif

  assign coin        = r_coin;
  assign full        = r_full;
  assign reject      = r_reject;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: constant vector table, directed multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_coin_feeder;
  import vend_pkg::*;

  localparam int DEPTH    = 4;
  localparam int DEBOUNCE = 3;

  logic          clock;
  logic          reset;
  logic          sense5;
  logic          sense10;
  logic          drv_np;
  logic          newspaper;
  logic [1:0]    coin;
  logic          full;
  logic          reject;
  feeder_state_t dbg_state;
`ifdef COIN_FEEDER_TALLY_EN
  logic [7:0]    tally;
`endif

  // Vending controller stand-in: 15-cent price, overpayment kept, no change.
  logic          ctrl_en;
  logic          ctrl_np;
  int            ctrl_total;

  assign newspaper = drv_np | (ctrl_en & ctrl_np);

  coin_feeder #(.DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clock       (clock),
    .reset       (reset),
    .sense5      (sense5),
    .sense10     (sense10),
    .newspaper   (newspaper),
    .coin        (coin),
    .full        (full),
    .reject      (reject),
    .o_dbg_state (dbg_state)
`ifdef COIN_FEEDER_TALLY_EN
    ,
    .tally       (tally)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cents(input logic [1:0] code);
    return (code == 2'b10) ? 10 : (code == 2'b01) ? 5 : 0;
  endfunction

  always @(posedge clock) begin
    if (!reset || !ctrl_en) begin
      ctrl_total <= 0;
      ctrl_np    <= 1'b0;
    end else begin
      ctrl_np <= 1'b0;
      if (coin != 2'b00) begin
        if (ctrl_total + cents(coin) >= 15) begin
          ctrl_np    <= 1'b1;
          ctrl_total <= 0;
        end else begin
          ctrl_total <= ctrl_total + cents(coin);
        end
      end
    end
  end

  // scoreboard / reference model
  int         n_checks;
  int         n_fail;
  logic [1:0] exp_q[$];
  int         run5;
  int         run10;
  logic [1:0] m_coin;
  logic       m_full;
  logic       m_reject;
  int         m_tally;
  int         n_coin5;
  int         n_coin10;
  int         n_rej;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    run5     = 0;
    run10    = 0;
    m_coin   = 2'b00;
    m_full   = 1'b0;
    m_reject = 1'b0;
    m_tally  = 0;
  endtask

  // One clock edge of behaviour: a coin qualifies on its DEBOUNCE-th
  // consecutive high sample; an issue needs a queued coin, no dispense, and
  // no coin presented in the previous cycle.
  task automatic model_step(input logic s5, input logic s10, input logic np);
    logic       ev5;
    logic       ev10;
    logic       was_full;
    logic       issue;
    logic [1:0] code;
    run5  = s5  ? ((run5  <= DEBOUNCE) ? run5  + 1 : run5)  : 0;
    run10 = s10 ? ((run10 <= DEBOUNCE) ? run10 + 1 : run10) : 0;
    ev5   = (run5  == DEBOUNCE) && s5;
    ev10  = (run10 == DEBOUNCE) && s10;
    was_full = (exp_q.size() == DEPTH);
    issue = (exp_q.size() > 0) && !np && (m_coin == 2'b00);
    code  = 2'b00;
    if (issue) code = exp_q.pop_front();
    m_reject = (ev5 && ev10) || ((ev5 != ev10) && was_full);
    if ((ev5 != ev10) && !was_full) exp_q.push_back(ev10 ? 2'b10 : 2'b01);
    m_coin  = code;
    m_full  = (exp_q.size() == DEPTH);
    m_tally = (m_tally + cents(code)) % 256;
  endtask

  // driver: one cycle of stimulus, then compare after the edge
  task automatic step(input logic s5, input logic s10, input logic np);
    sense5  = s5;
    sense10 = s10;
    drv_np  = np;
    model_step(s5, s10, np | (ctrl_en & ctrl_np));
    @(posedge clock);
    #1;
    check("coin", coin, m_coin);
    check("full", full, m_full);
    check("reject", reject, m_reject);
`ifdef COIN_FEEDER_TALLY_EN
    check("tally", tally, m_tally);
`endif
    if (coin == 2'b01) n_coin5++;
    if (coin == 2'b10) n_coin10++;
    if (reject) n_rej++;
  endtask

  task automatic insert(input logic is10, input logic np);
    repeat (DEBOUNCE) step(!is10, is10, np);
    step(1'b0, 1'b0, np);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    sense5  = 1'b0;
    sense10 = 1'b0;
    drv_np  = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       s5;
    logic       s10;
    logic       np;
    logic [1:0] coin;
    logic       full;
    logic       rej;
  } vec_t;

  vec_t tbl[18];
  int   exp_tr[7];
  int   np_tr[7];
  logic r5;
  logic r10;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_coin5  = 0;
    n_coin10 = 0;
    n_rej    = 0;
    ctrl_en  = 1'b0;
    reset    = 1'b0;
    sense5   = 1'b0;
    sense10  = 1'b0;
    drv_np   = 1'b0;
    model_reset();

    // single coin, glitch, simultaneous qualify
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

    #12;
    check("rst_coin", coin, 0);
    check("rst_full", full, 0);
    check("rst_reject", reject, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].s5, tbl[i].s10, tbl[i].np);
      check($sformatf("tbl%0d_coin", i), coin, tbl[i].coin);
      check($sformatf("tbl%0d_full", i), full, tbl[i].full);
      check($sformatf("tbl%0d_reject", i), reject, tbl[i].rej);
    end

    // full queue with dispense held off
    n_coin10 = 0;
    n_rej    = 0;
    for (int c = 0; c < 5; c++) insert(1'b1, 1'b1);
    check("s4_full", full, 1);
    check("s4_rejects", n_rej, 1);
    check("s4_held", n_coin10, 0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("s4_issued", n_coin10, 4);
    check("s4_drained", full, 0);

    // reset while a coin is on the bus
    for (int c = 0; c < 3; c++) insert(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("s6_issue", coin, 1);
    reset = 1'b0;
    #1;
    check("s6_rst_coin", coin, 0);
    check("s6_rst_full", full, 0);
    check("s6_rst_reject", reject, 0);
    model_reset();
    @(negedge clock);
    reset    = 1'b1;
    n_coin5  = 0;
    n_coin10 = 0;
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("s6_no_coin", n_coin5 + n_coin10, 0);

    // dispense handshake with the controller stand-in
    ctrl_en = 1'b1;
    insert(1'b1, 1'b1);
    insert(1'b1, 1'b1);
    insert(1'b0, 1'b1);
    exp_tr = '{2, 0, 2, 0, 0, 1, 0};
    np_tr  = '{0, 0, 0, 1, 0, 0, 0};
    for (int j = 0; j < 7; j++) begin
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("s5_coin%0d", j), coin, exp_tr[j]);
      check($sformatf("s5_np%0d", j), newspaper, np_tr[j]);
    end
    check("s5_ctrl_total", ctrl_total, 5);
`ifdef COIN_FEEDER_TALLY_EN
    check("s5_tally", tally, 25);
`endif
    ctrl_en = 1'b0;

    // randomized traffic against the model
    do_reset();
    r5  = 1'b0;
    r10 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) r5 = ~r5;
      if ($urandom_range(0, 3) == 0) r10 = ~r10;
      step(r5, r10, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
